bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
//  Per-frame bullet engine: owns N_TANKS x SLOTS bullet slots, allocates on fire, moves/reflects, retires.
//  Adds per-tank fire cooldown, lifetime and bounce limits, external kill and drop reporting.
//  Driven by tank/turret state; outputs feed the sprite renderer and hit detection.
// PARAMETERS
//  N_TANKS    2    tanks sharing the block
//  SLOTS      8    bullet slots per tank (>=1)
//  COOLDOWN   16   frames between accepted shots per tank (>=1)
//  LIFETIME   255  frames a bullet may live (age counter 8 bits)
//  MAX_BOUNCE 3    reflections allowed; the next edge hit retires the bullet
//  X_MAX      639  screen right;  Y_MAX 479 screen bottom (min is 0)
//  STEP       1    pixels per frame per axis;  BSIZE 4 bullet half-size
// PORTS
//  frame_clk     in   1                 frame-rate clock
//  Reset         in   1                 asynchronous, active-high
//  fire_req      in   N_TANKS           level; request shot this frame
//  spawn_x       in   N_TANKS*10        spawn centre x per tank (tank x + width/2)
//  spawn_y       in   N_TANKS*10        spawn centre y per tank
//  spawn_dir     in   N_TANKS*3         turret direction per tank
//  kill          in   N_TANKS*SLOTS     1 = retire slot k now (hit detected)
//  bullet_valid  out  N_TANKS*SLOTS     slot occupied; k = t*SLOTS+s
//  bullet_x      out  N_TANKS*SLOTS*10  centre x
//  bullet_y      out  N_TANKS*SLOTS*10  centre y
//  bullet_dir    out  N_TANKS*SLOTS*3   current direction
//  fire_ack      out  N_TANKS           1-frame pulse: shot accepted
//  fire_drop     out  N_TANKS           1-frame pulse: req while cooldown==0 but no free slot
//  active_cnt    out  N_TANKS*$clog2(SLOTS+1)  occupied slots per tank
// BEHAVIOUR
//  Reset: all valid=0, x/y/dir/age/bounce=0, cooldown=0, fire_ack/fire_drop=0, active_cnt=0.
//  All outputs registered; all state updates once per frame_clk edge.
//  Dir enc: 0 up,1 UL,2 L,3 DL,4 down,5 DR,6 R,7 UR; y grows downward.
//  Cooldown per tank: if >0 decrement each frame. fire_req while cooldown>0: ignored, no pulses.
//  Accept: fire_req & cooldown==0 & free slot -> lowest free slot (pre-kill occupancy) loads
//   valid=1, x/y/dir=spawn, age=0, bounce=0; cooldown<=COOLDOWN-1; fire_ack=1.
//   Spawned bullet is not moved in its spawn frame.
//  No free slot: fire_drop=1, cooldown unchanged (retry next frame).
//  Occupied slot per frame, priority order:
//   1 kill[k]=1 -> valid<=0 (slot not reallocatable until next frame).
//   2 age==LIFETIME-1 -> valid<=0.
//   3 move: nx=x+dx*STEP, ny=y+dy*STEP. Axis reflect if nx<BSIZE or nx>X_MAX-BSIZE
//     (same for y with Y_MAX): that axis holds position, dir mirrors
//     (x-reflect dir=(8-dir)%8, y-reflect dir=(4-dir)%8, corner applies both).
//     Any reflect counts one bounce; if bounce==MAX_BOUNCE already -> valid<=0 instead.
//   4 otherwise age<=age+1.
//  Unused slot: kill ignored; state held at 0.
//  Arithmetic: 11-bit signed intermediate for nx/ny; no wrap-around past 0 or 1023.
//  active_cnt reflects post-update occupancy (same edge as bullet_valid).
//  Reset mid-flight clears all slots and cooldowns immediately.
// STRUCTURE
//  Package tank_pkg: dir_t (3-bit enum), bullet_t struct {valid, dir, x, y, age, bounce},
//   dx/dy lookup function per dir, screen limits.
//  Sub-module bullet_step: combinational single-slot next state (move/reflect/bounce/age/retire),
//   instantiated N_TANKS*SLOTS via generate.
//  Top: per-tank cooldown counter, priority-encoder free-slot finder, slot registers, popcount.
// TESTING
//  1 Reset, tank0 fire_req held, spawn (216,216) dir 0 -> ack frame1, slot0 y=215 frame2;
//    next ack exactly 16 frames after first.
//  2 Fill all 8 slots (COOLDOWN=1 build), 9th req -> fire_drop=1, active_cnt=8; kill[3] -> next req fills slot3.
//  3 Bullet dir 6 at x=634 -> x held at 635 limit, dir becomes 2, bounce=1; 4th reflection -> valid=0.
//  4 Dir 7 at corner (635,4) -> dir 3 (both axes mirror), single bounce count.
//  5 Idle bullet in open field retires after exactly LIFETIME frames; kill and age-out same frame -> one retire.
//  6 Assert Reset mid-flight with 5 active -> all valid=0, cooldown 0, fire accepted first frame after release.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared types for the tank bullet engine.
// Direction encoding, slot record and per-direction step.
package tank_pkg;

  localparam int AGE_W     = 8;
  localparam int BNC_W     = 2;
  localparam int CRD_W     = 10;
  localparam int SCR_X_MAX = 639;
  localparam int SCR_Y_MAX = 479;

  typedef enum logic [2:0] {
    D_UP, D_UL, D_L, D_DL,
    D_DN, D_DR, D_R, D_UR
  } dir_t;

  typedef struct packed {
    logic             valid;
    dir_t             dir;
    logic [CRD_W-1:0] x;
    logic [CRD_W-1:0] y;
    logic [AGE_W-1:0] age;
    logic [BNC_W-1:0] bounce;
  } bullet_t;

  function automatic logic signed [10:0] dir_dx(dir_t d);
    logic signed [10:0] r;
    unique case (d)
      D_UL, D_L, D_DL: r = -11'sd1;
      D_DR, D_R, D_UR: r = 11'sd1;
      default:         r = 11'sd0;
    endcase
    return r;
  endfunction

  // y grows downward, so "up" is a negative step
  function automatic logic signed [10:0] dir_dy(dir_t d);
    logic signed [10:0] r;
    unique case (d)
      D_UP, D_UL, D_UR: r = -11'sd1;
      D_DL, D_DN, D_DR: r = 11'sd1;
      default:          r = 11'sd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bullet_step.sv
// Next-frame state of one bullet slot:
// kill, age-out, move with edge reflection and bounce limit.
module bullet_step
  import tank_pkg::*;
#(
  parameter int LIFETIME   = 255,
  parameter int MAX_BOUNCE = 3,
  parameter int X_MAX      = SCR_X_MAX,
  parameter int Y_MAX      = SCR_Y_MAX,
  parameter int STEP       = 1,
  parameter int BSIZE      = 4
) (
  input  bullet_t i_cur,
  input  logic    i_kill,
  output bullet_t o_nxt
);

  localparam logic signed [10:0] LO   = 11'(BSIZE);
  localparam logic signed [10:0] HI_X = 11'(X_MAX - BSIZE);
  localparam logic signed [10:0] HI_Y = 11'(Y_MAX - BSIZE);
  localparam logic signed [10:0] STP  = 11'(STEP);
  localparam logic [AGE_W-1:0] AGE_END = AGE_W'(LIFETIME - 1);
  localparam logic [BNC_W-1:0] BNC_END = BNC_W'(MAX_BOUNCE);

  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic               w_rx;
  logic               w_ry;
  logic               w_hit;
  logic [2:0]         w_dir;

  assign w_nx  = $signed({1'b0, i_cur.x}) + dir_dx(i_cur.dir) * STP;
  assign w_ny  = $signed({1'b0, i_cur.y}) + dir_dy(i_cur.dir) * STP;
  assign w_rx  = (w_nx < LO) || (w_nx > HI_X);
  assign w_ry  = (w_ny < LO) || (w_ny > HI_Y);
  assign w_hit = w_rx | w_ry;

  // x mirror is -d mod 8, y mirror is 4-d mod 8
  always_comb begin
    w_dir = i_cur.dir;
    if (w_rx) w_dir = 3'd0 - w_dir;
    if (w_ry) w_dir = 3'd4 - w_dir;
  end

  always_comb begin
    o_nxt = '0;
    if (i_cur.valid && !i_kill &&
        (i_cur.age != AGE_END) &&
        !(w_hit && (i_cur.bounce == BNC_END))) begin
      o_nxt     = i_cur;
      o_nxt.dir = dir_t'(w_dir);
      o_nxt.age = i_cur.age + 1'b1;
      if (!w_rx) o_nxt.x = w_nx[9:0];
      if (!w_ry) o_nxt.y = w_ny[9:0];
      if (w_hit) o_nxt.bounce = i_cur.bounce + 1'b1;
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// Per-frame bullet pool: slot allocation on fire, cooldown,
// per-slot stepping and occupancy counts.
module bullet_pool
  import tank_pkg::*;
#(
  parameter int N_TANKS    = 2,
  parameter int SLOTS      = 8,
  parameter int COOLDOWN   = 16,
  parameter int LIFETIME   = 255,
  parameter int MAX_BOUNCE = 3,
  parameter int X_MAX      = 639,
  parameter int Y_MAX      = 479,
  parameter int STEP       = 1,
  parameter int BSIZE      = 4
) (
  input  logic                              frame_clk,
  input  logic                              Reset,
  input  logic [N_TANKS-1:0]                fire_req,
  input  logic [N_TANKS*10-1:0]             spawn_x,
  input  logic [N_TANKS*10-1:0]             spawn_y,
  input  logic [N_TANKS*3-1:0]              spawn_dir,
  input  logic [N_TANKS*SLOTS-1:0]          kill,
  output logic [N_TANKS*SLOTS-1:0]          bullet_valid,
  output logic [N_TANKS*SLOTS*10-1:0]       bullet_x,
  output logic [N_TANKS*SLOTS*10-1:0]       bullet_y,
  output logic [N_TANKS*SLOTS*3-1:0]        bullet_dir,
  output logic [N_TANKS-1:0]                fire_ack,
  output logic [N_TANKS-1:0]                fire_drop,
  output logic [N_TANKS*$clog2(SLOTS+1)-1:0] active_cnt
);

  localparam int NS  = N_TANKS * SLOTS;
  localparam int CW  = $clog2(SLOTS + 1);
  localparam int CDW = $clog2(COOLDOWN + 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN - 1);

  bullet_t            r_slot [NS];
  bullet_t            w_step [NS];
  bullet_t            w_nxt  [NS];
  logic [CDW-1:0]     r_cd   [N_TANKS];
  logic [CW-1:0]      r_cnt  [N_TANKS];
  logic [CW-1:0]      w_cnt  [N_TANKS];
  logic [N_TANKS-1:0] r_ack;
  logic [N_TANKS-1:0] r_drop;
  logic [N_TANKS-1:0] w_acc;
  logic [N_TANKS-1:0] w_drp;
  logic [N_TANKS-1:0] w_free;

  for (genvar k = 0; k < NS; k++) begin : g_slot
    bullet_step #(
      .LIFETIME  (LIFETIME),
      .MAX_BOUNCE(MAX_BOUNCE),
      .X_MAX     (X_MAX),
      .Y_MAX     (Y_MAX),
      .STEP      (STEP),
      .BSIZE     (BSIZE)
    ) u_step (
      .i_cur (r_slot[k]),
      .i_kill(kill[k]),
      .o_nxt (w_step[k])
    );
    assign bullet_valid[k]       = r_slot[k].valid;
    assign bullet_x[k*10 +: 10]  = r_slot[k].x;
    assign bullet_y[k*10 +: 10]  = r_slot[k].y;
    assign bullet_dir[k*3 +: 3]  = r_slot[k].dir;
  end

  for (genvar t = 0; t < N_TANKS; t++) begin : g_cnt
    assign active_cnt[t*CW +: CW] = r_cnt[t];
  end

  assign fire_ack  = r_ack;
  assign fire_drop = r_drop;

  // Free slot search uses pre-kill occupancy, so a killed slot
  // only becomes allocatable on the following frame.
  always_comb begin
    for (int k = 0; k < NS; k++) w_nxt[k] = w_step[k];
    w_free = '0;
    w_acc  = '0;
    w_drp  = '0;
    for (int t = 0; t < N_TANKS; t++) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (!r_slot[t*SLOTS+s].valid && !w_free[t]) begin
          w_free[t] = 1'b1;
          if (fire_req[t] && (r_cd[t] == '0)) begin
            w_nxt[t*SLOTS+s]       = '0;
            w_nxt[t*SLOTS+s].valid = 1'b1;
            w_nxt[t*SLOTS+s].dir   = dir_t'(spawn_dir[t*3 +: 3]);
            w_nxt[t*SLOTS+s].x     = spawn_x[t*10 +: 10];
            w_nxt[t*SLOTS+s].y     = spawn_y[t*10 +: 10];
          end
        end
      end
      w_acc[t] = fire_req[t] && (r_cd[t] == '0) && w_free[t];
      w_drp[t] = fire_req[t] && (r_cd[t] == '0) && !w_free[t];
    end
  end

  always_comb begin
    for (int t = 0; t < N_TANKS; t++) begin
      w_cnt[t] = '0;
      for (int s = 0; s < SLOTS; s++)
        w_cnt[t] = w_cnt[t] + CW'(w_nxt[t*SLOTS+s].valid);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < NS; k++) r_slot[k] <= '0;
      for (int t = 0; t < N_TANKS; t++) begin
        r_cd[t]  <= '0;
        r_cnt[t] <= '0;
      end
      r_ack  <= '0;
      r_drop <= '0;
    end else begin
      for (int k = 0; k < NS; k++) r_slot[k] <= w_nxt[k];
      for (int t = 0; t < N_TANKS; t++) begin
        r_cnt[t] <= w_cnt[t];
        if (r_cd[t] != '0)
          r_cd[t] <= r_cd[t] - 1'b1;
        else if (w_acc[t])
          r_cd[t] <= CD_LOAD;
      end
      r_ack  <= w_acc;
      r_drop <= w_drp;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// Bench for bullet_pool: two builds (COOLDOWN 16 and 1) share stimulus,
// each checked every frame against an integer model of the rules.
module tb_bullet_pool;

  localparam int NT   = 2;
  localparam int NSL  = 8;
  localparam int NS   = 16;
  localparam int LIFE = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   fire_req;
  logic [19:0]  sx, sy;
  logic [5:0]   sd;
  logic [15:0]  kill;
  logic [15:0]  v0, v1;
  logic [159:0] x0, x1, y0, y1;
  logic [47:0]  d0, d1;
  logic [1:0]   a0, a1, dr0, dr1;
  logic [7:0]   c0, c1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bullet_pool u_dut (
    .frame_clk(clk), .Reset(rst), .fire_req(fire_req),
    .spawn_x(sx), .spawn_y(sy), .spawn_dir(sd), .kill(kill),
    .bullet_valid(v0), .bullet_x(x0), .bullet_y(y0), .bullet_dir(d0),
    .fire_ack(a0), .fire_drop(dr0), .active_cnt(c0)
  );

  bullet_pool #(.COOLDOWN(1)) u_dut1 (
    .frame_clk(clk), .Reset(rst), .fire_req(fire_req),
    .spawn_x(sx), .spawn_y(sy), .spawn_dir(sd), .kill(kill),
    .bullet_valid(v1), .bullet_x(x1), .bullet_y(y1), .bullet_dir(d1),
    .fire_ack(a1), .fire_drop(dr1), .active_cnt(c1)
  );

  // reference model, one copy per build
  int mv   [2][NS];
  int mx   [2][NS];
  int my   [2][NS];
  int md   [2][NS];
  int mage [2][NS];
  int mbn  [2][NS];
  int mcd  [2][NT];
  int mack [2][NT];
  int mdrp [2][NT];
  int cdv  [2] = '{16, 1};

  function automatic int dxf(int d);
    case (d)
      1, 2, 3: return -1;
      5, 6, 7: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int dyf(int d);
    case (d)
      0, 1, 7: return -1;
      3, 4, 5: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic clr(int i, int k);
    mv[i][k] = 0; mx[i][k] = 0; my[i][k] = 0;
    md[i][k] = 0; mage[i][k] = 0; mbn[i][k] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NS; k++) clr(i, k);
      for (int t = 0; t < NT; t++) begin
        mcd[i][t] = 0; mack[i][t] = 0; mdrp[i][t] = 0;
      end
    end
  endtask

  task automatic model_step(int i);
    int  pre [NS];
    int  nx, ny, k;
    bit  rx, ry, found;
    for (int j = 0; j < NS; j++) pre[j] = mv[i][j];
    for (int j = 0; j < NS; j++) begin
      if (mv[i][j] == 0) continue;
      if (kill[j] || mage[i][j] == LIFE - 1) begin
        clr(i, j);
        continue;
      end
      nx = mx[i][j] + dxf(md[i][j]);
      ny = my[i][j] + dyf(md[i][j]);
      rx = (nx < 4) || (nx > 635);
      ry = (ny < 4) || (ny > 475);
      if ((rx || ry) && mbn[i][j] == 3) begin
        clr(i, j);
        continue;
      end
      if (rx) md[i][j] = (8 - md[i][j]) % 8; else mx[i][j] = nx;
      if (ry) md[i][j] = (12 - md[i][j]) % 8; else my[i][j] = ny;
      if (rx || ry) mbn[i][j]++;
      mage[i][j]++;
    end
    for (int t = 0; t < NT; t++) begin
      mack[i][t] = 0;
      mdrp[i][t] = 0;
      if (mcd[i][t] > 0) mcd[i][t]--;
      else if (fire_req[t]) begin
        found = 0;
        for (int s = 0; s < NSL && !found; s++) begin
          k = t * NSL + s;
          if (pre[k] == 0) begin
            found = 1;
            mv[i][k] = 1; mage[i][k] = 0; mbn[i][k] = 0;
            mx[i][k] = int'(sx[t*10 +: 10]);
            my[i][k] = int'(sy[t*10 +: 10]);
            md[i][k] = int'(sd[t*3 +: 3]);
          end
        end
        if (found) begin
          mack[i][t] = 1;
          mcd[i][t]  = cdv[i] - 1;
        end else mdrp[i][t] = 1;
      end
    end
  endtask

  task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_inst(int i, logic [15:0] v, logic [159:0] x,
                            logic [159:0] y, logic [47:0] d, logic [1:0] a,
                            logic [1:0] dr, logic [7:0] c);
    logic [15:0]  ev;
    logic [159:0] ex, ey;
    logic [47:0]  ed;
    logic [1:0]   ea, edr;
    logic [7:0]   ec;
    int n;
    ev = '0; ex = '0; ey = '0; ed = '0; ea = '0; edr = '0; ec = '0;
    for (int k = 0; k < NS; k++) begin
      ev[k]         = (mv[i][k] != 0);
      ex[k*10 +: 10] = 10'(mx[i][k]);
      ey[k*10 +: 10] = 10'(my[i][k]);
      ed[k*3 +: 3]  = 3'(md[i][k]);
    end
    for (int t = 0; t < NT; t++) begin
      n = 0;
      for (int s = 0; s < NSL; s++) n += mv[i][t*NSL+s];
      ec[t*4 +: 4] = 4'(n);
      ea[t]  = (mack[i][t] != 0);
      edr[t] = (mdrp[i][t] != 0);
    end
    chk($sformatf("u%0d valid", i), 160'(v), 160'(ev));
    chk($sformatf("u%0d x", i), x, ex);
    chk($sformatf("u%0d y", i), y, ey);
    chk($sformatf("u%0d dir", i), 160'(d), 160'(ed));
    chk($sformatf("u%0d ack", i), 160'(a), 160'(ea));
    chk($sformatf("u%0d drop", i), 160'(dr), 160'(edr));
    chk($sformatf("u%0d cnt", i), 160'(c), 160'(ec));
  endtask

  task automatic check_all();
    check_inst(0, v0, x0, y0, d0, a0, dr0, c0);
    check_inst(1, v1, x1, y1, d1, a1, dr1, c1);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    fire_req = '0;
    kill     = '0;
    rst      = 1'b1;
    #3;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_spawn(int t, int x, int y, int d);
    sx[t*10 +: 10] = 10'(x);
    sy[t*10 +: 10] = 10'(y);
    sd[t*3 +: 3]   = 3'(d);
  endtask

  typedef struct {
    string nm;
    int    sx, sy, sd, n;
    int    ev, ex, ey, ed;
  } vec_t;

  vec_t vt [13];
  int   first, second;

  initial begin
    vt[0]  = '{"up_one",       216, 216, 0, 1,   1, 216, 215, 0};
    vt[1]  = '{"right_edge",   634, 240, 6, 1,   1, 635, 240, 6};
    vt[2]  = '{"right_refl",   634, 240, 6, 2,   1, 635, 240, 2};
    vt[3]  = '{"corner",       635,   4, 7, 1,   1, 635,   4, 3};
    vt[4]  = '{"left_refl",      4, 240, 2, 1,   1,   4, 240, 6};
    vt[5]  = '{"bottom_refl",  320, 475, 4, 1,   1, 320, 475, 0};
    vt[6]  = '{"diag_ul",      320, 240, 1, 3,   1, 317, 237, 1};
    vt[7]  = '{"bounce3",        0, 240, 6, 3,   1,   0, 240, 2};
    vt[8]  = '{"bounce4_ret",    0, 240, 6, 4,   0,   0,   0, 0};
    vt[9]  = '{"corner_b3",      0,   0, 7, 3,   1,   0,   0, 3};
    vt[10] = '{"corner_ret",     0,   0, 7, 4,   0,   0,   0, 0};
    vt[11] = '{"age_254",      320, 240, 6, 254, 1, 574, 240, 6};
    vt[12] = '{"age_255",      320, 240, 6, 255, 0,   0,   0, 0};

    fire_req = '0; kill = '0; sx = '0; sy = '0; sd = '0;
    #1;
    do_reset();

    // first shot on frame 1, next exactly 16 frames later
    set_spawn(0, 216, 216, 0);
    set_spawn(1, 300, 300, 4);
    fire_req = 2'b01;
    first = -1; second = -1;
    for (int f = 1; f <= 20; f++) begin
      tick();
      if (a0[0]) begin
        if (first < 0) first = f;
        else if (second < 0) second = f;
      end
      if (f == 2) chk("t1 y frame2", 160'(y0[9:0]), 160'(215));
    end
    chk("t1 first ack", 160'(first), 160'(1));
    chk("t1 second ack", 160'(second), 160'(17));

    // fill all slots on the COOLDOWN=1 build
    do_reset();
    set_spawn(0, 320, 240, 0);
    fire_req = 2'b01;
    repeat (8) tick();
    chk("t2 cnt full", 160'(c1[3:0]), 160'(8));
    tick();
    chk("t2 drop", 160'(dr1[0]), 160'(1));
    chk("t2 no ack", 160'(a1[0]), 160'(0));
    kill = 16'h0008;
    tick();
    kill = '0;
    chk("t2 kill slot3", 160'(v1[3]), 160'(0));
    chk("t2 drop at kill", 160'(dr1[0]), 160'(1));
    set_spawn(0, 100, 200, 6);
    tick();
    chk("t2 refill ack", 160'(a1[0]), 160'(1));
    chk("t2 slot3 valid", 160'(v1[3]), 160'(1));
    chk("t2 slot3 x", 160'(x1[30 +: 10]), 160'(100));
    chk("t2 slot3 y", 160'(y1[30 +: 10]), 160'(200));
    chk("t2 slot3 dir", 160'(d1[9 +: 3]), 160'(6));
    fire_req = '0;

    // movement, reflection, bounce limit and lifetime vectors
    for (int i = 0; i < 13; i++) begin
      do_reset();
      set_spawn(0, vt[i].sx, vt[i].sy, vt[i].sd);
      fire_req = 2'b01;
      tick();
      fire_req = '0;
      repeat (vt[i].n) tick();
      chk({vt[i].nm, " valid"}, 160'(v0[0]), 160'(vt[i].ev));
      chk({vt[i].nm, " x"}, 160'(x0[9:0]), 160'(vt[i].ex));
      chk({vt[i].nm, " y"}, 160'(y0[9:0]), 160'(vt[i].ey));
      chk({vt[i].nm, " dir"}, 160'(d0[2:0]), 160'(vt[i].ed));
    end

    // kill on the age-out frame retires once
    do_reset();
    set_spawn(0, 320, 240, 6);
    fire_req = 2'b01;
    tick();
    fire_req = '0;
    repeat (254) tick();
    chk("t5 alive", 160'(v0[0]), 160'(1));
    kill = 16'h0001;
    tick();
    kill = '0;
    chk("t5 retired", 160'(v0[0]), 160'(0));
    chk("t5 cnt", 160'(c0[3:0]), 160'(0));

    // reset mid-flight
    do_reset();
    set_spawn(0, 320, 240, 2);
    fire_req = 2'b01;
    repeat (5) tick();
    chk("t6 five active", 160'(c1[3:0]), 160'(5));
    do_reset();
    chk("t6 valid cleared", 160'(v1), 160'(0));
    fire_req = 2'b01;
    tick();
    chk("t6 ack u0", 160'(a0[0]), 160'(1));
    chk("t6 ack u1", 160'(a1[0]), 160'(1));
    fire_req = '0;

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      fire_req = 2'($urandom_range(0, 3));
      for (int t = 0; t < NT; t++)
        set_spawn(t, $urandom_range(0, 639), $urandom_range(0, 479),
                  $urandom_range(0, 7));
      kill = '0;
      for (int k = 0; k < NS; k++)
        if ($urandom_range(0, 39) == 0) kill[k] = 1'b1;
      if (c % 700 == 699) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
